branch_predictor: RTL and testbench

//   Parametrised branch target buffer (BTB) with saturating-counter direction prediction.

---
 rtl/branch_predictor.sv | 138 +++++++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; 1-cycle registered lookup, EX-side training.
// Latency: prediction valid the edge after an accepted lookup. Backpressure: stall holds pred_*, flush clears them.
// Optional BP_STATS_EN adds lookup/mispredict statistics counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target
`ifdef BP_STATS_EN
    ,
    input  logic              update_mispredict,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_ONE << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_ONE;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ENTRIES-1:0] ent_valid;
    logic [TAG_W-1:0]   ent_tag    [ENTRIES];
    logic [ADDR_W-1:0]  ent_target [ENTRIES];
    logic [CNT_W-1:0]   ent_cnt    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [ADDR_W-1:0] lk_target;

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [CNT_W-1:0]  cnt_cur;
    logic [CNT_W-1:0]  cnt_next;
    logic              wr_en;

    // Word-offset bits play no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, lookup_pc[1:0], update_pc[1:0]};

    // Lookup reads the table before this edge's update lands (no bypass).
    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit    = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ent_cnt[lk_idx][CNT_W-1];
    assign lk_target = lk_hit ? ent_target[lk_idx] : '0;

    assign up_idx  = update_pc[IDX_W+1:2];
    assign up_tag  = update_pc[ADDR_W-1:IDX_W+2];
    assign up_hit  = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
    assign cnt_cur = ent_cnt[up_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (update_taken && (cnt_cur != CNT_MAX)) begin
            cnt_next = cnt_cur + CNT_ONE;
        end else if (!update_taken && (cnt_cur != '0)) begin
            cnt_next = cnt_cur - CNT_ONE;
        end
    end

    // A not-taken miss leaves the table untouched; taken misses allocate over any occupant.
    assign wr_en = update_valid && (up_hit || update_taken);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_tag[i]    <= '0;
                ent_target[i] <= '0;
                ent_cnt[i]    <= CNT_WNT;
            end
        end else if (wr_en) begin
            ent_valid[up_idx] <= 1'b1;
            ent_tag[up_idx]   <= up_tag;
            ent_cnt[up_idx]   <= up_hit ? cnt_next : CNT_WT;
            if (update_taken) begin
                ent_target[up_idx] <= update_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (flush) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!stall) begin
            pred_valid  <= lookup_valid;
            pred_hit    <= lookup_valid && lk_hit;
            pred_taken  <= lookup_valid && lk_taken;
            pred_target <= lookup_valid ? lk_target : '0;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_valid && !stall && !flush) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (update_valid && update_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed spec scenarios, then randomized traffic against a table model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 4;

    logic        clk;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        flush;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
`ifdef BP_STATS_EN
    logic        update_mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
    int unsigned m_lookups;
    int unsigned m_mispredicts;
`endif

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .ADDR_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .lookup_valid(lookup_valid),
        .lookup_pc(lookup_pc),
        .stall(stall),
        .flush(flush),
        .pred_valid(pred_valid),
        .pred_hit(pred_hit),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target)
`ifdef BP_STATS_EN
        ,
        .update_mispredict(update_mispredict),
        .stat_lookups(stat_lookups),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference table: plain integers, counter semantics straight from the saturating rule.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [34:0] exp_pred;
    logic [34:0] exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 2 ** (CNT_W - 1) - 1;
        end
        exp_pred = '0;
`ifdef BP_STATS_EN
        m_lookups     = 0;
        m_mispredicts = 0;
`endif
    endfunction

    task automatic step(input logic lv, input logic [31:0] lpc, input logic st, input logic fl,
                        input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        int  i;
        bit  hit;
        lookup_valid  = lv;
        lookup_pc     = lpc;
        stall         = st;
        flush         = fl;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utg;
        i   = idx_of(lpc);
        hit = m_valid[i] && (m_tag[i] == tag_of(lpc));
        if (fl) exp_pred = '0;
        else if (!st) begin
            if (lv) exp_pred = {1'b1, hit, hit && (m_cnt[i] >= 2 ** (CNT_W - 1)), hit ? m_tgt[i] : 32'h0};
            else    exp_pred = '0;
        end
`ifdef BP_STATS_EN
        update_mispredict = 1'($urandom % 2);
        if (lv && !st && !fl) m_lookups++;
        if (uv && update_mispredict) m_mispredicts++;
`endif
        if (uv) begin
            i = idx_of(upc);
            if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
                if (ut) begin
                    m_cnt[i] = (m_cnt[i] + 1 > 2 ** CNT_W - 1) ? 2 ** CNT_W - 1 : m_cnt[i] + 1;
                    m_tgt[i] = utg;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upc);
                m_tgt[i]   = utg;
                m_cnt[i]   = 2 ** (CNT_W - 1);
            end
        end
        @(posedge clk);
        exp_q.push_back(exp_pred);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    endfunction

    // Monitor: one expected prediction per clock edge while out of reset.
    initial begin : monitor
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred", {29'h0, pred_valid, pred_hit, pred_taken, pred_target}, {29'h0, e});
            end
        end
    end

    task automatic check_reset_outputs(string name);
        check(name, {29'h0, pred_valid, pred_hit, pred_taken, pred_target}, 64'h0);
`ifdef BP_STATS_EN
        check({name, "_stats"}, {stat_lookups, stat_mispredicts}, 64'h0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0; flush = 1'b0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
`ifdef BP_STATS_EN
        update_mispredict = 1'b0;
`endif
        model_reset();
        #2;
        check_reset_outputs("reset_state");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // cold miss
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);       // allocate WT
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // hit taken 0x80
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // hit not taken
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);        // stays at 0
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h1234);     // 0 -> 1, new target
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // still not taken
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200);      // alias evicts 0x40
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h83, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // unaligned PC
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // stall holds
        step(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);        // flush beats stall
        step(1'b1, 32'h48, 1'b0, 1'b0, 1'b1, 32'h48, 1'b1, 32'h999);     // same-index, pre-update read
        step(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4c, 1'b1, 32'h77);       // update proceeds under flush
        step(1'b1, 32'h4c, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();

`ifdef BP_STATS_EN
        check("stats_directed", {stat_lookups, stat_mispredicts}, {m_lookups, m_mispredicts});
`endif

        // Asynchronous reset away from any clock edge; table must come back cold.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // cold again

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom % 4 != 0), rand_pc(), 1'($urandom % 6 == 0), 1'($urandom % 10 == 0),
                 1'($urandom % 2), rand_pc(), 1'($urandom % 2), $urandom);
        end
        idle();

        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());
`ifdef BP_STATS_EN
        check("stats_random", {stat_lookups, stat_mispredicts}, {m_lookups, m_mispredicts});
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
